// File: rtl/wb_la_master.sv
// wb_la_master: Wishbone classic initiator that runs one single read/write per accepted command.
// Optional REQ timeout abort enabled by defining WB_LA_MASTER_TIMEOUT_EN.
module wb_la_master #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int TO_CYCLES = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_we,
    input  logic [AW-1:0]   cmd_adr,
    input  logic [DW-1:0]   cmd_dat,
    input  logic [DW/8-1:0] cmd_sel,
    output logic            rsp_valid,
    output logic [DW-1:0]   rsp_dat,
    output logic            rsp_err,
    output logic            busy,
    output logic            wbm_cyc_o,
    output logic            wbm_stb_o,
    output logic            wbm_we_o,
    output logic [DW/8-1:0] wbm_sel_o,
    output logic [AW-1:0]   wbm_adr_o,
    output logic [DW-1:0]   wbm_dat_o,
    input  logic [DW-1:0]   wbm_dat_i,
    input  logic            wbm_ack_i
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
    state_t state, state_next;
    logic accept, ack, timeout;
    assign accept    = cmd_valid && state == IDLE;
    assign ack       = wbm_ack_i && state == REQ;
    assign cmd_ready = state == IDLE;
    assign wbm_cyc_o = state == REQ;
    assign wbm_stb_o = state == REQ;
    assign rsp_valid = state == RESP;
    assign busy      = state != IDLE;
`ifdef WB_LA_MASTER_TIMEOUT_EN
    logic [15:0] cnt;
    // ack takes priority over an expiry on the same edge
    assign timeout = state == REQ && !wbm_ack_i && cnt == 16'(TO_CYCLES - 1);
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) cnt <= '0;
        else if (accept) cnt <= '0;
        else if (state == REQ && !wbm_ack_i) cnt <= cnt + 16'd1;
    end
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = cmd_valid ? REQ : IDLE;
            REQ:     state_next = (ack || timeout) ? RESP : REQ;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= IDLE;
        else state <= state_next;
    end
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= '0;
            wbm_adr_o <= '0;
            wbm_dat_o <= '0;
            rsp_dat   <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                wbm_we_o  <= cmd_we;
                wbm_sel_o <= cmd_sel;
                wbm_adr_o <= cmd_adr;
                wbm_dat_o <= cmd_dat;
            end else if (state == RESP) begin
                wbm_we_o  <= 1'b0;
                wbm_sel_o <= '0;
                wbm_adr_o <= '0;
                wbm_dat_o <= '0;
            end
            if (ack) begin
                rsp_dat <= wbm_we_o ? '0 : wbm_dat_i;
                rsp_err <= 1'b0;
            end else if (timeout) begin
                rsp_dat <= '0;
                rsp_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wb_la_master.sv
// tb_wb_la_master: table-driven transactions with a response scoreboard, plus
// hand sequences for held cmd_valid, spurious ack, reset abort and timeout.
module tb_wb_la_master;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [AW-1:0] cmd_adr = '0;
    logic [DW-1:0] cmd_dat = '0;
    logic [DW/8-1:0] cmd_sel = '0;
    logic rsp_valid, rsp_err, busy;
    logic [DW-1:0] rsp_dat;
    logic wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [DW/8-1:0] wbm_sel_o;
    logic [AW-1:0] wbm_adr_o;
    logic [DW-1:0] wbm_dat_o;
    logic [DW-1:0] wbm_dat_i = '0;
    logic wbm_ack_i = 1'b0;

    always #5 clk = ~clk;

    wb_la_master #(.AW(AW), .DW(DW), .TO_CYCLES(TO)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_err(rsp_err), .busy(busy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
    );

    typedef struct {
        logic [DW-1:0] dat;
        logic          err;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic          we;
        logic [AW-1:0] adr;
        logic [DW-1:0] dat;
        logic [3:0]    sel;
        int            delay;
        logic [DW-1:0] rdata;
        int            exp_cyc;
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pop_rsp();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_unexpected_rsp", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("rsp_dat", rsp_dat, e.dat);
            chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        end
    endtask

    // delay = REQ cycle on which ack is driven; 0 means the slave never acks
    task automatic do_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input logic [3:0] sel, input int delay, input logic [DW-1:0] rdata,
                          input int exp_cyc, input logic exp_err);
        int cycles;
        bit got;
        chk("ready_before", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        wbm_dat_i = rdata;
        sb.push_back('{dat: (we || exp_err) ? '0 : rdata, err: exp_err});
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
        chk("req_we", {31'd0, wbm_we_o}, {31'd0, we});
        chk("req_adr", wbm_adr_o, adr);
        chk("req_dat", wbm_dat_o, dat);
        chk("req_sel", {28'd0, wbm_sel_o}, {28'd0, sel});
        cycles = 0;
        got = 0;
        for (int i = 0; i < 64 && !got; i++) begin
            if (rsp_valid) begin
                got = 1;
                chk("cyc_in_resp", {31'd0, wbm_cyc_o}, 32'd0);
                pop_rsp();
            end else begin
                if (wbm_cyc_o && wbm_stb_o) cycles++;
                wbm_ack_i = (delay != 0 && cycles == delay);
                @(negedge clk);
                wbm_ack_i = 1'b0;
            end
        end
        chk("rsp_seen", {31'd0, got}, 32'd1);
        chk("cyc_cycles", cycles, exp_cyc);
        @(negedge clk);
        chk("rsp_one_cycle", {31'd0, rsp_valid}, 32'd0);
        chk("idle_ready", {31'd0, cmd_ready}, 32'd1);
        chk("idle_sel", {28'd0, wbm_sel_o}, 32'd0);
        chk("idle_we", {31'd0, wbm_we_o}, 32'd0);
        chk("idle_adr", wbm_adr_o, 32'd0);
    endtask

    initial begin
        vec_t vecs[5];
        int acc, rsps, last;
        vecs[0] = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 32'hFFFF_FFFF, 2};
        vecs[1] = '{1'b0, 32'h3000_0000, 32'h0,         4'hF, 1, 32'h1234_5678, 1};
        vecs[2] = '{1'b1, 32'h3000_0010, 32'h0000_A5A5, 4'h3, 1, 32'h7777_7777, 1};
        vecs[3] = '{1'b0, 32'h3000_0010, 32'h0,         4'hC, 3, 32'hCAFE_F00D, 3};
        vecs[4] = '{1'b0, 32'h3000_0020, 32'h0,         4'hF, 5, 32'h0000_0000, 5};

        #12;
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            do_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                   vecs[i].delay, vecs[i].rdata, vecs[i].exp_cyc, 1'b0);

        // cmd_valid held: one transaction per acceptance, accepts every 3 cycles
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0000; cmd_sel = 4'hF;
        wbm_dat_i = 32'h0BAD_F00D;
        acc = 0; rsps = 0; last = -1;
        for (int i = 0; i < 9; i++) begin
            if (cmd_valid && cmd_ready) begin
                if (last >= 0) chk("accept_spacing", i - last, 32'd3);
                last = i;
                acc++;
                sb.push_back('{dat: wbm_dat_i, err: 1'b0});
            end
            if (rsp_valid) begin
                rsps++;
                pop_rsp();
            end
            wbm_ack_i = wbm_cyc_o;
            @(negedge clk);
        end
        cmd_valid = 1'b0; wbm_ack_i = 1'b0;
        chk("held_accepts", acc, 32'd3);
        chk("held_rsps", rsps, 32'd3);

        // spurious ack in IDLE
        wbm_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("spur_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            chk("spur_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        end
        wbm_ack_i = 1'b0;
        @(negedge clk);

        // reset while in REQ
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0040; cmd_dat = 32'h1111_2222; cmd_sel = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("pre_rst_cyc", {31'd0, wbm_cyc_o}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_cyc", {31'd0, wbm_cyc_o}, 32'd0);
        chk("rst_mid_stb", {31'd0, wbm_stb_o}, 32'd0);
        chk("rst_mid_we", {31'd0, wbm_we_o}, 32'd0);
        @(negedge clk);
        chk("rst_mid_rsp", {31'd0, rsp_valid}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_rsp", {31'd0, rsp_valid}, 32'd0);
        chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
        do_txn(1'b0, 32'h3000_0044, 32'h0, 4'h5, 2, 32'h89AB_CDEF, 2, 1'b0);

`ifdef WB_LA_MASTER_TIMEOUT_EN
        do_txn(1'b0, 32'h3000_0050, 32'h0, 4'hF, 0, 32'h5555_AAAA, TO, 1'b1);
        do_txn(1'b0, 32'h3000_0054, 32'h0, 4'hF, TO, 32'h55AA_55AA, TO, 1'b0);
`endif

        chk("sb_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
